// File: rtl/sync_fifo_prog.sv
// Parametrised single-clock FIFO with programmable almost-full/almost-empty thresholds,
// synchronous flush and occupancy count. Define SYNC_FIFO_FWFT_EN for first-word fall-through.
module sync_fifo_prog #(
    parameter int FIFO_WIDTH = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [FIFO_WIDTH-1:0] data_in,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic                  flush,
    input  logic [CNT_W-1:0]      afull_thresh,
    input  logic [CNT_W-1:0]      aempty_thresh,
    output logic [FIFO_WIDTH-1:0] data_out,
    output logic                  wr_ack,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  full,
    output logic                  empty,
    output logic                  almostfull,
    output logic                  almostempty,
    output logic [CNT_W-1:0]      count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    logic [FIFO_WIDTH-1:0] mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_r;
    logic [PTR_W-1:0]      rd_ptr_r;
    logic [CNT_W-1:0]      count_r;
    logic                  wr_ack_r;
    logic                  overflow_r;
    logic                  underflow_r;

    logic                  full_s;
    logic                  empty_s;
    logic                  wr_accept_s;
    logic                  rd_accept_s;
    logic [PTR_W-1:0]      wr_ptr_nxt_s;
    logic [PTR_W-1:0]      rd_ptr_nxt_s;
    logic [CNT_W-1:0]      count_nxt_s;

    assign full_s   = (count_r == CNT_FULL);
    assign empty_s  = (count_r == {CNT_W{1'b0}});

    // Thresholds outside 1..FIFO_DEPTH-1 (or zero for almost-empty) disable the flag.
    assign full        = full_s;
    assign empty       = empty_s;
    assign almostfull  = (afull_thresh != {CNT_W{1'b0}}) && (afull_thresh < CNT_FULL) &&
                         (count_r >= afull_thresh) && !full_s;
    assign almostempty = (aempty_thresh != {CNT_W{1'b0}}) &&
                         (count_r <= aempty_thresh) && !empty_s;
    assign count       = count_r;
    assign wr_ack      = wr_ack_r;
    assign overflow    = overflow_r;
    assign underflow   = underflow_r;

    // Acceptance decisions, pointer wrap and next occupancy from the pre-edge count.
    always_comb begin
        wr_accept_s = 1'b0;
        rd_accept_s = 1'b0;
        count_nxt_s = count_r;
        if (flush) begin
            wr_accept_s = 1'b0;
            rd_accept_s = 1'b0;
        end else begin
            wr_accept_s = wr_en && !full_s;
            rd_accept_s = rd_en && !empty_s;
        end
        case ({wr_accept_s, rd_accept_s})
            2'b10:   count_nxt_s = count_r + CNT_W'(1);
            2'b01:   count_nxt_s = count_r - CNT_W'(1);
            default: count_nxt_s = count_r;
        endcase
        if (wr_ptr_r == PTR_LAST) begin
            wr_ptr_nxt_s = {PTR_W{1'b0}};
        end else begin
            wr_ptr_nxt_s = wr_ptr_r + PTR_W'(1);
        end
        if (rd_ptr_r == PTR_LAST) begin
            rd_ptr_nxt_s = {PTR_W{1'b0}};
        end else begin
            rd_ptr_nxt_s = rd_ptr_r + PTR_W'(1);
        end
    end

    // Storage array; contents survive reset and flush.
    always_ff @(posedge clk) begin
        if (rst_n && wr_accept_s) begin
            mem_r[wr_ptr_r] <= data_in;
        end
    end

    // Pointers, occupancy and single-cycle status pulses.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr_r    <= {PTR_W{1'b0}};
            rd_ptr_r    <= {PTR_W{1'b0}};
            count_r     <= {CNT_W{1'b0}};
            wr_ack_r    <= 1'b0;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            if (wr_accept_s) begin
                wr_ptr_r <= wr_ptr_nxt_s;
            end
            if (rd_accept_s) begin
                rd_ptr_r <= rd_ptr_nxt_s;
            end
            count_r     <= count_nxt_s;
            wr_ack_r    <= wr_accept_s;
            overflow_r  <= wr_en && full_s;
            underflow_r <= rd_en && empty_s;
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    assign data_out = mem_r[rd_ptr_r];
`else
    logic [FIFO_WIDTH-1:0] data_out_r;

    // Registered read data; flush and rejected reads leave it untouched.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_out_r <= {FIFO_WIDTH{1'b0}};
        end else if (rd_accept_s) begin
            data_out_r <= mem_r[rd_ptr_r];
        end
    end

    assign data_out = data_out_r;
`endif

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Self-checking bench for sync_fifo_prog: depth-8 and depth-5 instances driven in parallel
// and compared against a queue-based reference model.
module tb_sync_fifo_prog;

    typedef logic [15:0] q_t[$];

    logic        clk = 1'b0;
    logic        rst_n, wr_en, rd_en, flush;
    logic [15:0] data_in;
    logic [3:0]  at8, ae8;
    logic [2:0]  at5, ae5;

    logic [15:0] d8_dout, d5_dout;
    logic        d8_ack, d8_ovf, d8_unf, d8_full, d8_empty, d8_af, d8_ae;
    logic        d5_ack, d5_ovf, d5_unf, d5_full, d5_empty, d5_af, d5_ae;
    logic [3:0]  d8_count;
    logic [2:0]  d5_count;

    int total = 0;
    int bad   = 0;

    q_t          q8, q5;
    logic [15:0] e_dout8, e_dout5;
    logic        e_ack8, e_ovf8, e_unf8, e_ack5, e_ovf5, e_unf5;
    logic [15:0] dcnt;

    always #5 clk = ~clk;

    sync_fifo_prog #(.FIFO_WIDTH(16), .FIFO_DEPTH(8)) u_d8 (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .wr_en(wr_en), .rd_en(rd_en),
        .flush(flush), .afull_thresh(at8), .aempty_thresh(ae8), .data_out(d8_dout),
        .wr_ack(d8_ack), .overflow(d8_ovf), .underflow(d8_unf), .full(d8_full),
        .empty(d8_empty), .almostfull(d8_af), .almostempty(d8_ae), .count(d8_count)
    );

    sync_fifo_prog #(.FIFO_WIDTH(16), .FIFO_DEPTH(5)) u_d5 (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .wr_en(wr_en), .rd_en(rd_en),
        .flush(flush), .afull_thresh(at5), .aempty_thresh(ae5), .data_out(d5_dout),
        .wr_ack(d5_ack), .overflow(d5_ovf), .underflow(d5_unf), .full(d5_full),
        .empty(d5_empty), .almostfull(d5_af), .almostempty(d5_ae), .count(d5_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock of FIFO behaviour as a queue: what the FIFO holds and what it reports.
    task automatic step_model(input int d, inout q_t q, inout logic [15:0] dout,
                              output logic ack, output logic ovf, output logic unf);
        int  n;
        bit  do_w, do_r;
        n = q.size();
        if (!rst_n) begin
            q.delete();
            dout = 16'h0000;
            ack = 1'b0; ovf = 1'b0; unf = 1'b0;
        end else if (flush) begin
            q.delete();
            ack = 1'b0; ovf = 1'b0; unf = 1'b0;
        end else begin
            do_w = wr_en && (n < d);
            do_r = rd_en && (n > 0);
            if (do_r) dout = q.pop_front();
            if (do_w) q.push_back(data_in);
            ack = do_w;
            ovf = wr_en && (n == d);
            unf = rd_en && (n == 0);
        end
    endtask

    function automatic logic [3:0] exp_flags(int n, int d, int at, int ae);
        logic f, e, af, aef;
        f   = (n == d);
        e   = (n == 0);
        af  = (at >= 1) && (at < d) && (n >= at) && (n < d);
        aef = (ae >= 1) && (n > 0) && (n <= ae);
        return {f, e, af, aef};
    endfunction

    task automatic check_all();
        logic [3:0] f8, f5;
        f8 = exp_flags(q8.size(), 8, int'(at8), int'(ae8));
        f5 = exp_flags(q5.size(), 5, int'(at5), int'(ae5));
        chk("d8_count", d8_count, q8.size());
        chk("d8_flags", {d8_full, d8_empty, d8_af, d8_ae}, f8);
        chk("d8_pulses", {d8_ack, d8_ovf, d8_unf}, {e_ack8, e_ovf8, e_unf8});
        chk("d5_count", d5_count, q5.size());
        chk("d5_flags", {d5_full, d5_empty, d5_af, d5_ae}, f5);
        chk("d5_pulses", {d5_ack, d5_ovf, d5_unf}, {e_ack5, e_ovf5, e_unf5});
`ifdef SYNC_FIFO_FWFT_EN
        if (q8.size() > 0) chk("d8_dout", d8_dout, q8[0]);
        if (q5.size() > 0) chk("d5_dout", d5_dout, q5[0]);
`else
        chk("d8_dout", d8_dout, e_dout8);
        chk("d5_dout", d5_dout, e_dout5);
`endif
    endtask

    task automatic cycle();
        @(posedge clk);
        step_model(8, q8, e_dout8, e_ack8, e_ovf8, e_unf8);
        step_model(5, q5, e_dout5, e_ack5, e_ovf5, e_unf5);
        #1;
        check_all();
    endtask

    task automatic step(input logic w, input logic r, input logic [15:0] d, input logic f);
        wr_en = w; rd_en = r; data_in = d; flush = f;
        cycle();
    endtask

    task automatic set_thr(input int a, input int e);
        at8 = 4'(a); ae8 = 4'(e);
        at5 = 3'(a); ae5 = 3'(e);
    endtask

    initial begin
        rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0; data_in = 16'h0000;
        set_thr(6, 2);
        step(1'b0, 1'b0, 16'h0000, 1'b0);
        rst_n = 1'b1;

        // reset in the middle of a write burst
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 16'h0100 + 16'(i), 1'b0);
        rst_n = 1'b0;
        step(1'b1, 1'b0, 16'h01ff, 1'b0);
        rst_n = 1'b1;

        // fill past depth 5, then read back
        for (int i = 1; i <= 6; i++) step(1'b1, 1'b0, 16'(i), 1'b0);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 16'h0000, 1'b0);

        // pointer wrap-around
        dcnt = 16'h0200;
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 3; i++) begin step(1'b1, 1'b0, dcnt, 1'b0); dcnt++; end
            for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 16'h0000, 1'b0);
        end

        // simultaneous read/write at full and at empty
        step(1'b0, 1'b0, 16'h0000, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 16'h0300 + 16'(i), 1'b0);
        step(1'b1, 1'b1, 16'h03aa, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 16'h0000, 1'b0);
        step(1'b1, 1'b1, 16'h0abc, 1'b0);

        // thresholds: walk depth 8 from empty to full, then change afull live
        step(1'b0, 1'b0, 16'h0000, 1'b1);
        for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 16'h0400 + 16'(i), 1'b0);
        step(1'b0, 1'b0, 16'h0000, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 16'h0500 + 16'(i), 1'b0);
        set_thr(3, 2);
        #1;
        check_all();
        chk("af_live_d8", d8_af, 1'b1);

        // flush overrides a concurrent write; data_out keeps its value
        step(1'b1, 1'b0, 16'h0777, 1'b1);
        step(1'b1, 1'b0, 16'h0555, 1'b0);
        step(1'b0, 1'b1, 16'h0000, 1'b0);
        step(1'b0, 1'b0, 16'h0000, 1'b0);

        // zero thresholds disable both almost flags
        set_thr(0, 0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 16'h0600 + 16'(i), 1'b0);

        // randomized traffic with occasional flush, reset and threshold changes
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 15) == 0) set_thr($urandom_range(0, 9), $urandom_range(0, 9));
            rst_n = ($urandom_range(0, 63) != 0);
            step(1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 50),
                 16'($urandom), 1'($urandom_range(0, 31) == 0));
        end
        rst_n = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
